// File: rtl/neo_spike_detector.sv
// Adaptive-threshold spike detector on the NEO energy stream: windowed-mean threshold,
// peak/timestamp capture per spike, forced event on over-long spikes, refractory hold-off.
module neo_spike_detector #(
   parameter int         M        = 16,
   parameter int         LOG2_WIN = 6,
   parameter logic [7:0] K_SCALE  = 8'h50,
   parameter int         REFRACT  = 20,
   parameter int         MAX_W    = 32,
   parameter int         TS_W     = 16
) (
   input  logic                Clk,
   input  logic                reset,
   input  logic                neo_valid,
   input  logic signed [M-1:0] neo_data,
   output logic                spike_valid,
   output logic [M-1:0]        spike_peak,
   output logic [TS_W-1:0]     spike_time,
   output logic [M-1:0]        threshold,
   output logic                thr_valid
);

   localparam int AW  = M + LOG2_WIN;
   localparam int WCW = $clog2(MAX_W + 1);
   localparam int RCW = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;
   localparam logic [M-1:0] THR_MAX = {1'b0, {(M-1){1'b1}}};

   localparam logic [1:0] S_CALIB = 2'd0;
   localparam logic [1:0] S_ARMED = 2'd1;
   localparam logic [1:0] S_PEAK  = 2'd2;
   localparam logic [1:0] S_REFR  = 2'd3;

   logic [1:0]          state_q, state_d;
   logic [AW-1:0]       acc_q, acc_d;
   logic [LOG2_WIN-1:0] wpos_q, wpos_d;
   logic [TS_W-1:0]     ts_q, ts_d;
   logic [M-1:0]        thr_q, thr_d;
   logic                thr_valid_q, thr_valid_d;
   logic [M-1:0]        peak_q, peak_d;
   logic [TS_W-1:0]     peak_ts_q, peak_ts_d;
   logic [WCW-1:0]      wcnt_q, wcnt_d;
   logic [RCW-1:0]      rcnt_q, rcnt_d;
   logic                spike_valid_q, spike_valid_d;
   logic [M-1:0]        spike_peak_q, spike_peak_d;
   logic [TS_W-1:0]     spike_time_q, spike_time_d;

   logic [M-1:0]        x;
   logic [AW-1:0]       sum;
   logic [AW+7:0]       scaled;
   logic                win_done;
   logic                emit;

   always_comb begin
      x        = neo_data[M-1] ? '0 : neo_data;
      sum      = acc_q + AW'(x);
      // mean and scale kept at full width so saturation sees every overflow bit
      scaled   = (((AW+8)'(sum) >> LOG2_WIN) * (AW+8)'(K_SCALE)) >> 4;
      win_done = &wpos_q;
      emit     = 1'b0;

      state_d       = state_q;
      acc_d         = acc_q;
      wpos_d        = wpos_q;
      ts_d          = ts_q;
      thr_d         = thr_q;
      thr_valid_d   = thr_valid_q;
      peak_d        = peak_q;
      peak_ts_d     = peak_ts_q;
      wcnt_d        = wcnt_q;
      rcnt_d        = rcnt_q;
      spike_valid_d = 1'b0;
      spike_peak_d  = spike_peak_q;
      spike_time_d  = spike_time_q;

      if (neo_valid) begin
         ts_d   = ts_q + 1'b1;
         wpos_d = wpos_q + 1'b1;
         if (win_done) begin
            acc_d       = '0;
            thr_d       = (scaled > (AW+8)'(THR_MAX)) ? THR_MAX : scaled[M-1:0];
            thr_valid_d = 1'b1;
         end else begin
            acc_d = sum;
         end

         // detection compares against the threshold in force before this sample
         case (state_q)
            S_CALIB: if (win_done) state_d = S_ARMED;
            S_ARMED: begin
               if (x > thr_q) begin
                  state_d   = S_PEAK;
                  peak_d    = x;
                  peak_ts_d = ts_q;
                  wcnt_d    = WCW'(1);
               end
            end
            S_PEAK: begin
               if (x > thr_q) begin
                  if (x > peak_q) begin
                     peak_d    = x;
                     peak_ts_d = ts_q;
                  end
                  wcnt_d = wcnt_q + 1'b1;
                  emit   = (wcnt_d == WCW'(MAX_W));
               end else begin
                  emit = 1'b1;
               end
               if (emit) begin
                  spike_valid_d = 1'b1;
                  spike_peak_d  = peak_d;
                  spike_time_d  = peak_ts_d;
                  rcnt_d        = RCW'(REFRACT);
                  state_d       = (REFRACT == 0) ? S_ARMED : S_REFR;
               end
            end
            default: begin
               rcnt_d = rcnt_q - 1'b1;
               if (rcnt_q == RCW'(1)) state_d = S_ARMED;
            end
         endcase
      end
   end

   always_ff @(posedge Clk or negedge reset) begin
      if (!reset) begin
         state_q       <= S_CALIB;
         acc_q         <= '0;
         wpos_q        <= '0;
         ts_q          <= '0;
         thr_q         <= '0;
         thr_valid_q   <= 1'b0;
         peak_q        <= '0;
         peak_ts_q     <= '0;
         wcnt_q        <= '0;
         rcnt_q        <= '0;
         spike_valid_q <= 1'b0;
         spike_peak_q  <= '0;
         spike_time_q  <= '0;
      end else begin
         state_q       <= state_d;
         acc_q         <= acc_d;
         wpos_q        <= wpos_d;
         ts_q          <= ts_d;
         thr_q         <= thr_d;
         thr_valid_q   <= thr_valid_d;
         peak_q        <= peak_d;
         peak_ts_q     <= peak_ts_d;
         wcnt_q        <= wcnt_d;
         rcnt_q        <= rcnt_d;
         spike_valid_q <= spike_valid_d;
         spike_peak_q  <= spike_peak_d;
         spike_time_q  <= spike_time_d;
      end
   end

   assign spike_valid = spike_valid_q;
   assign spike_peak  = spike_peak_q;
   assign spike_time  = spike_time_q;
   assign threshold   = thr_q;
   assign thr_valid   = thr_valid_q;

endmodule

// File: tb/tb_neo_spike_detector.sv
// Randomized and directed bench for neo_spike_detector: a sample-level reference model
// queues expected events, and a monitor matches them against every spike_valid pulse.
module tb_neo_spike_detector;
   localparam int M       = 16;
   localparam int TS_W    = 16;
   localparam int REFRACT = 20;
   localparam int MAX_W   = 32;
   localparam int WIN     = 64;
   localparam int KQ44    = 80;

   logic                Clk = 1'b0;
   logic                reset = 1'b0;
   logic                neo_valid = 1'b0;
   logic signed [M-1:0] neo_data = '0;
   logic                spike_valid;
   logic [M-1:0]        spike_peak;
   logic [TS_W-1:0]     spike_time;
   logic [M-1:0]        threshold;
   logic                thr_valid;

   neo_spike_detector #(.M(M), .LOG2_WIN(6), .K_SCALE(8'h50), .REFRACT(REFRACT),
                        .MAX_W(MAX_W), .TS_W(TS_W)) dut (
      .Clk(Clk), .reset(reset), .neo_valid(neo_valid), .neo_data(neo_data),
      .spike_valid(spike_valid), .spike_peak(spike_peak), .spike_time(spike_time),
      .threshold(threshold), .thr_valid(thr_valid));

   always #5 Clk = ~Clk;

   typedef struct { int peak; int ts; } ev_t;
   ev_t exp_q[$];
   ev_t mon_e;
   logic prev_sv = 1'b0;

   int checks = 0;
   int errors = 0;

   // reference model state, in plain integers
   int m_ts, m_sum, m_cnt, m_thr, m_thrv, m_in, m_pk, m_pts, m_len, m_ref;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_ts = 0; m_sum = 0; m_cnt = 0; m_thr = 0; m_thrv = 0;
      m_in = 0; m_pk = 0; m_pts = 0; m_len = 0; m_ref = 0;
   endtask

   task automatic model_emit();
      ev_t e;
      e.peak = m_pk;
      e.ts   = m_pts;
      exp_q.push_back(e);
      m_in  = 0;
      m_ref = REFRACT;
   endtask

   task automatic model_step(input int raw);
      int x, ts, t;
      x    = (raw < 0) ? 0 : raw;
      ts   = m_ts;
      m_ts = (m_ts + 1) % (1 << TS_W);
      if (m_thrv != 0) begin
         if (m_ref > 0) m_ref--;
         else if (m_in == 0) begin
            if (x > m_thr) begin m_in = 1; m_pk = x; m_pts = ts; m_len = 1; end
         end else if (x > m_thr) begin
            m_len++;
            if (x > m_pk) begin m_pk = x; m_pts = ts; end
            if (m_len == MAX_W) model_emit();
         end else model_emit();
      end
      m_sum += x;
      m_cnt++;
      if (m_cnt == WIN) begin
         t = (m_sum / WIN) * KQ44 / 16;
         if (t > 32767) t = 32767;
         m_thr = t; m_thrv = 1; m_sum = 0; m_cnt = 0;
      end
   endtask

   task automatic send(input int raw);
      logic [31:0] r;
      r         = raw;
      neo_valid = 1'b1;
      neo_data  = r[M-1:0];
      model_step(raw);
      @(posedge Clk); #1;
      neo_valid = 1'b0;
      chk("threshold", threshold, m_thr);
      chk("thr_valid", thr_valid, m_thrv);
   endtask

   task automatic send_n(input int n, input int raw);
      for (int i = 0; i < n; i++) send(raw);
   endtask

   task automatic idle(input int n);
      logic [M-1:0] thr0;
      logic         tv0;
      thr0 = threshold;
      tv0  = thr_valid;
      for (int i = 0; i < n; i++) begin
         neo_valid = 1'b0;
         neo_data  = 16'sd30000;
         @(posedge Clk); #1;
         chk("hold_threshold", threshold, thr0);
         chk("hold_thr_valid", thr_valid, tv0);
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_spike_valid"}, spike_valid, 0);
      chk({tag, "_spike_peak"}, spike_peak, 0);
      chk({tag, "_spike_time"}, spike_time, 0);
      chk({tag, "_threshold"}, threshold, 0);
      chk({tag, "_thr_valid"}, thr_valid, 0);
   endtask

   task automatic do_reset();
      @(negedge Clk); #1;
      neo_valid = 1'b0;
      reset = 1'b0;
      #1;
      check_zero("reset");
      chk("pending_events_at_reset", exp_q.size(), 0);
      exp_q.delete();
      model_reset();
      repeat (2) @(posedge Clk);
      #3 reset = 1'b1;
      @(posedge Clk); #1;
   endtask

   always @(negedge Clk) begin
      if (spike_valid) begin
         if (prev_sv) begin
            checks++; errors++;
            $display("FAIL pulse_width: spike_valid high 2 cycles at %0t", $time);
         end
         if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_event: peak %0d time %0d, none expected at %0t",
                     spike_peak, spike_time, $time);
         end else begin
            mon_e = exp_q.pop_front();
            chk("spike_peak", spike_peak, mon_e.peak);
            chk("spike_time", spike_time, mon_e.ts);
         end
      end
      prev_sv <= spike_valid;
   end

   initial begin
      int r, v;
      model_reset();
      #1 check_zero("por");
      #13 reset = 1'b1;
      @(posedge Clk); #1;

      // calibration to 500, then a spike peaking at ts 65 and an ignored refractory sample
      send_n(64, 100);
      chk("calib_threshold_500", threshold, 500);
      send(600); send(900); send(700); send(50);
      send(800); send_n(19, 100);
      send_n(5, 100);

      // equal peaks keep the earliest timestamp
      do_reset();
      send_n(64, 100);
      send(900); send(900); send(100);
      send_n(25, 100);

      // over-long spike forces an event, remainder falls in refractory
      do_reset();
      send_n(64, 100);
      send_n(40, 1000);
      send_n(30, 100);

      // negative samples clamp to zero; later a saturated threshold blocks full-scale input
      do_reset();
      send_n(32, -32768);
      send_n(32, 200);
      chk("clamp_threshold_500", threshold, 500);
      send_n(64, 20000);
      send_n(64, 20000);
      chk("sat_threshold", threshold, 32767);
      send_n(10, 32767);

      // reset in the middle of a spike, then a hold with neo_valid low mid-spike
      do_reset();
      send_n(64, 100);
      send(600); send(900);
      do_reset();
      send_n(64, 100);
      send(300); send(900);
      idle(10);
      send(700); send(50);
      send_n(25, 100);

      // randomized traffic with gaps
      do_reset();
      send_n(64, $urandom_range(50, 150));
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 9) == 0) idle($urandom_range(1, 3));
         r = $urandom_range(0, 99);
         if (r < 70)      v = $urandom_range(50, 150);
         else if (r < 85) v = $urandom_range(300, 4000);
         else if (r < 92) v = -$urandom_range(1, 32768);
         else             v = $urandom_range(32000, 32767);
         send(v);
      end

      repeat (3) @(posedge Clk);
      #1 chk("events_outstanding", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
